// File: rtl/stepper_step_decoder.sv
// stepper_step_decoder: rebuilds step position and direction from an active-low one-hot winding drive
// ports: clk; rst async high; drive_in A..D = bit 3..0; zero, clear_fault sync pulses;
//   position signed step count; dir last step direction; step_pulse one per step;
//   locked, fault state flags; fault_code 01 illegal / 10 skipped phase; stalled no step for STALL_CYCLES
module stepper_step_decoder #(
  parameter int POS_W = 16,
  parameter int FILTER_LEN = 4,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              drive_in,
  input  logic                    zero,
  input  logic                    clear_fault,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    locked,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic                    stalled
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(STALL_CYCLES + 1);
  localparam logic [1:0] UNLOCKED = 2'd0, LOCKED = 2'd1, FAULT = 2'd2;
  logic [3:0] s1, s2, p, acc;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [1:0] state, ph, nph, delta;
  logic legal, take, fwd, rev;
  assign legal = s2 == 4'b1110 || s2 == 4'b1101 || s2 == 4'b1011 || s2 == 4'b0111;
  assign nph = {~s2[3] | ~s2[2], ~s2[3] | ~s2[1]};
  assign delta = nph - ph;
  // p holds the previous synchronized sample, so cnt tracks how long s2 has been unchanged
  assign take = s2 == p && cnt == CW'(FILTER_LEN) && s2 != acc;
  assign fwd = take && state == LOCKED && legal && delta == 2'd1;
  assign rev = take && state == LOCKED && legal && delta == 2'd3;
  assign locked = state == LOCKED;
  assign fault = state == FAULT;
  assign stalled = tmr == TW'(STALL_CYCLES);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 4'hF;
      s2 <= 4'hF;
      p <= 4'hF;
      acc <= 4'hF;
      cnt <= '0;
      tmr <= '0;
      state <= UNLOCKED;
      ph <= '0;
      position <= '0;
      dir <= 1'b0;
      step_pulse <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      s1 <= drive_in;
      s2 <= s1;
      p <= s2;
      cnt <= s2 != p ? CW'(1) : cnt == CW'(FILTER_LEN) ? cnt : cnt + CW'(1);
      acc <= take ? s2 : acc;
      ph <= take && legal && state != FAULT ? nph : ph;
      step_pulse <= fwd | rev;
      dir <= fwd | rev ? fwd : dir;
      position <= zero ? '0 : fwd ? position + POS_W'(1) : rev ? position - POS_W'(1) : position;
      // in LOCKED every accepted pattern either steps or faults, both of which restart the timer
      tmr <= state != LOCKED || take ? '0 : stalled ? tmr : tmr + TW'(1);
      if (state == FAULT) begin
        if (clear_fault) begin
          state <= UNLOCKED;
          fault_code <= 2'b00;
        end
      end else if (take && state == UNLOCKED && legal) begin
        state <= LOCKED;
      end else if (take && state == LOCKED && (!legal || delta == 2'd2)) begin
        state <= FAULT;
        fault_code <= legal ? 2'b10 : 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_stepper_step_decoder.sv
// tb_stepper_step_decoder: random and directed check of stepper_step_decoder against a pattern-history model
module tb_stepper_step_decoder;
  localparam int PW = 4, FL = 4, SC = 20, HL = FL + 3;
  logic clk, rst, zero, clear_fault;
  logic [3:0] drive_in;
  logic [PW-1:0] pos;
  logic dir, step_pulse, locked, fault, stalled;
  logic [1:0] fault_code;
  int n_cmp = 0, n_bad = 0, npulse = 0, cp = 0;
  logic [3:0] hist [HL];
  logic [3:0] macc;
  int ms, mph, mpos, mt, mcode;
  bit mdir, mpulse;

  stepper_step_decoder #(.POS_W(PW), .FILTER_LEN(FL), .STALL_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .drive_in(drive_in), .zero(zero), .clear_fault(clear_fault),
    .position(pos), .dir(dir), .step_pulse(step_pulse), .locked(locked), .fault(fault),
    .fault_code(fault_code), .stalled(stalled)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int ph_of(input logic [3:0] pt);
    logic [3:0] one = 4'b0001;
    for (int i = 0; i < 4; i++) if (pt == ~(one << i)) return i;
    return -1;
  endfunction

  function automatic logic [3:0] pat_of(input int ph);
    logic [3:0] one = 4'b0001;
    return ~(one << ph);
  endfunction

  // model: a pattern counts once its synchronized sample has been seen FL+1 times in a row
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < HL; i++) hist[i] = 4'hF;
      macc = 4'hF; ms = 0; mph = 0; mpos = 0; mt = 0; mcode = 0; mdir = 0; mpulse = 0;
    end else begin
      automatic bit stable = 1;
      automatic int np, d, step = 0, was = ms;
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = drive_in;
      for (int i = 3; i <= 2 + FL; i++) if (hist[i] != hist[2]) stable = 0;
      np = ph_of(hist[2]);
      mpulse = 0;
      if (stable && hist[2] != macc) begin
        macc = hist[2];
        if (was == 0 && np >= 0) begin ms = 1; mph = np; end
        else if (was == 1) begin
          d = (np - mph + 4) % 4;
          if (np < 0) begin ms = 2; mcode = 1; end
          else if (d == 2) begin ms = 2; mcode = 2; end
          else begin step = d == 1 ? 1 : -1; mph = np; end
        end
      end
      if (was == 2 && clear_fault) begin ms = 0; mcode = 0; end
      if (step != 0) begin mpulse = 1; mdir = step > 0; end
      mpos = zero ? 0 : mpos + step;
      mt = (was == 1 && ms == 1 && step == 0) ? (mt < SC ? mt + 1 : mt) : 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      automatic logic [PW-1:0] e = PW'(mpos);
      chk("position", int'(pos), int'(e));
      chk("dir", int'(dir), int'(mdir));
      chk("step_pulse", int'(step_pulse), int'(mpulse));
      chk("locked", int'(locked), int'(ms == 1));
      chk("fault", int'(fault), int'(ms == 2));
      chk("fault_code", int'(fault_code), mcode);
      chk("stalled", int'(stalled), int'(mt >= SC));
      if (step_pulse) npulse++;
    end
  end

  task automatic hold(input logic [3:0] pt, input int n);
    drive_in = pt;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_zero();
    zero = 1; @(negedge clk); zero = 0;
  endtask

  initial begin
    int np0;
    rst = 1; zero = 0; clear_fault = 0; drive_in = 4'hF;
    #1;
    chk("reset_outputs", int'({pos, dir, step_pulse, locked, fault, fault_code, stalled}), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    hold(4'hF, 3);
    np0 = npulse;
    hold(4'b1110, 10);
    #1;
    chk("t1_locked", int'(locked), 1);
    chk("t1_pos", int'(pos), 0);
    chk("t1_no_pulse", npulse - np0, 0);
    np0 = npulse;
    hold(4'b1101, 6);
    chk("t2_not_early", int'(step_pulse), 0);
    hold(4'b1101, 1);
    chk("t2_latency", int'(step_pulse), 1);
    hold(4'b1101, 3);
    hold(4'b1011, 10); hold(4'b0111, 10); hold(4'b1110, 10);
    #1;
    chk("t2_pulses", npulse - np0, 4);
    chk("t2_pos", int'(pos), 4);
    chk("t2_dir", int'(dir), 1);
    pulse_zero();
    hold(4'b0111, 10); hold(4'b1011, 10);
    chk("t3_pos", int'(pos), 14);
    chk("t3_dir", int'(dir), 0);
    hold(4'b1101, 3); hold(4'b1011, 10);
    chk("t3_glitch", int'(pos), 14);
    hold(4'b1101, 10); hold(4'b1110, 10); hold(4'b1011, 10);
    chk("t4_fault", int'(fault), 1);
    chk("t4_code", int'(fault_code), 2);
    chk("t4_pos", int'(pos), 12);
    hold(4'b0000, 10);
    chk("t4_held", int'(fault), 1);
    clear_fault = 1; @(negedge clk); clear_fault = 0;
    chk("t4_cleared", int'({locked, fault, fault_code}), 0);
    pulse_zero();
    hold(4'b1110, 10);
    for (int i = 1; i <= 7; i++) hold(pat_of(i % 4), 10);
    chk("t5_pos7", int'(pos), 7);
    hold(4'b1110, 10);
    chk("t5_wrap", int'(pos), 8);
    hold(4'b1101, 6);
    zero = 1; @(negedge clk); zero = 0;
    chk("t5_zero_pos", int'(pos), 0);
    chk("t5_zero_pulse", int'(step_pulse), 1);
    repeat (19) @(negedge clk);
    chk("t6_not_yet", int'(stalled), 0);
    @(negedge clk);
    chk("t6_stalled", int'(stalled), 1);
    hold(4'b1011, 7);
    chk("t6_step_clears", int'(stalled), 0);
    chk("t6_pos", int'(pos), 1);
    hold(4'b0111, 3);
    chk("t6_pre_rst", int'(locked), 1);
    #2 rst = 1;
    #1 chk("t6_async_rst", int'({pos, dir, step_pulse, locked, fault, fault_code, stalled}), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    hold(4'hF, 3);
    cp = 0;
    for (int it = 0; it < 500; it++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 70) begin
        cp = (cp + (($urandom % 2) != 0 ? 1 : 3)) % 4;
        hold(pat_of(cp), $urandom_range(1, 9));
      end else if (r < 76) begin
        cp = (cp + 2) % 4;
        hold(pat_of(cp), $urandom_range(4, 9));
      end else if (r < 82) hold(4'($urandom), $urandom_range(1, 9));
      else if (r < 88) pulse_zero();
      else if (r < 97) begin
        clear_fault = 1; @(negedge clk); clear_fault = 0;
      end else begin
        #2 rst = 1;
        #1 chk("rnd_async_rst", int'({pos, locked, fault, stalled}), 0);
        @(negedge clk);
        rst = 0;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
